// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (cpu, dbg) for the single data_memory port with cpu priority,
// a dbg starvation override and one-cycle read-response routing. Define DBG_LOCK_EN to enable the dbg bus lock.
module data_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_lock,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DBG_LOCK_EN
  typedef enum logic [1:0] {OPEN = 2'd0, STARVED = 2'd1, LOCKED = 2'd2} arbState_t;
`else
  typedef enum logic [1:0] {OPEN = 2'd0, STARVED = 2'd1} arbState_t;
`endif

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  arbState_t  state, nextState;
  logic [3:0] starveCount, nextStarveCount;
  logic [1:0] respOwner;
  logic       cpuGnt, dbgGnt;
  logic       lockReq;

`ifdef DBG_LOCK_EN
  assign lockReq = dbg_lock;
`else
  logic unusedLock;
  assign unusedLock = dbg_lock;
  assign lockReq    = 1'b0;
`endif

  // Grant selection: cpu first in OPEN, dbg first in STARVED, dbg only in LOCKED.
  always_comb begin
    cpuGnt = 1'b0;
    dbgGnt = 1'b0;
    case (state)
      STARVED: begin
        dbgGnt = dbg_req;
        cpuGnt = cpu_req & ~dbg_req;
      end
`ifdef DBG_LOCK_EN
      LOCKED: begin
        dbgGnt = dbg_req;
      end
`endif
      default: begin
        cpuGnt = cpu_req;
        dbgGnt = dbg_req & ~cpu_req;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = 2'b00;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (cpuGnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_size  = cpu_size;
      mem_re    = ~cpu_we;
      mem_we    = cpu_we;
    end else if (dbgGnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_size  = dbg_size;
      mem_re    = ~dbg_we;
      mem_we    = dbg_we;
    end
  end

  // Counter tracks consecutive denied dbg cycles and saturates at the limit.
  always_comb begin
    nextStarveCount = starveCount;
    if (dbgGnt || !dbg_req) begin
      nextStarveCount = 4'd0;
    end else if (starveCount < StarveLimit) begin
      nextStarveCount = starveCount + 4'd1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      STARVED: begin
        if (dbgGnt && lockReq) begin
          nextState = arbState_t'(2'd2);
        end else if (dbgGnt || !dbg_req) begin
          nextState = OPEN;
        end
      end
`ifdef DBG_LOCK_EN
      LOCKED: begin
        if (!dbg_lock) begin
          nextState = OPEN;
        end
      end
`endif
      default: begin
        if (dbgGnt && lockReq) begin
          nextState = arbState_t'(2'd2);
        end else if (nextStarveCount == StarveLimit) begin
          nextState = STARVED;
        end else begin
          nextState = OPEN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= OPEN;
      starveCount <= 4'd0;
      respOwner   <= 2'b00;
    end else begin
      state       <= nextState;
      starveCount <= nextStarveCount;
      respOwner   <= {dbgGnt & ~dbg_we, cpuGnt & ~cpu_we};
    end
  end

  assign cpu_gnt    = cpuGnt;
  assign dbg_gnt    = dbgGnt;
  assign cpu_stall  = cpu_req & ~cpuGnt;
  assign cpu_rvalid = respOwner[0];
  assign dbg_rvalid = respOwner[1];
  assign cpu_rdata  = respOwner[0] ? mem_rdata : '0;
  assign dbg_rdata  = respOwner[1] ? mem_rdata : '0;

endmodule
